// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: scalar widths, ALU/branch/operand-select
// enums, RV64I opcode constants and the decoded control bundle.
// No ports (package).
package decode_stage_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND} ALU_CTR;
    typedef enum logic [2:0] {NOBR, BEQ, BNE, BLT, BGE, BLTU, BGEU} BRA;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} OPA_SEL;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} OPB_SEL;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef struct packed {
        u64         pc;
        ALU_CTR     alu_ctrl;
        BRA         take_branch;
        OPA_SEL     op_a_sel;
        OPB_SEL     op_b_sel;
        u64         imm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       jump;
        logic       illegal;
    } decode_bundle_t;

    localparam decode_bundle_t BUNDLE_RESET = '{
        pc: '0, alu_ctrl: ADD, take_branch: NOBR, op_a_sel: A_RS1, op_b_sel: B_RS2,
        imm: '0, rs1: '0, rs2: '0, rd: '0, reg_write: 1'b0, mem_read: 1'b0,
        mem_write: 1'b0, mem_size: '0, jump: 1'b0, illegal: 1'b0};

    // alt is instr[30]; it only selects SUB for register-register ops,
    // since for OP-IMM that bit belongs to the immediate.
    function automatic ALU_CTR alu_from_f3(input logic [2:0] f3, input logic alt,
                                           input logic is_op);
        ALU_CTR r;
        case (f3)
            3'b000:  r = (is_op && alt) ? SUB : ADD;
            3'b001:  r = SLL;
            3'b010:  r = SLT;
            3'b011:  r = SLTU;
            3'b100:  r = XOR;
            3'b101:  r = alt ? SRA : SRL;
            3'b110:  r = OR;
            default: r = AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded bundle fields.
// slave : the decode stage (consumes in_*, out_ready; drives in_ready, out_*).
// master: the surrounding pipeline / testbench.
interface decode_stage_if import decode_stage_pkg::*; ();

    logic       in_valid;
    logic       in_ready;
    u64         in_pc;
    u32         in_instr;
    logic       out_valid;
    logic       out_ready;
    u64         out_pc;
    ALU_CTR     out_alu_ctrl;
    BRA         out_take_branch;
    OPA_SEL     out_op_a_sel;
    OPB_SEL     out_op_b_sel;
    u64         out_imm;
    logic [4:0] out_rs1;
    logic [4:0] out_rs2;
    logic [4:0] out_rd;
    logic       out_reg_write;
    logic       out_mem_read;
    logic       out_mem_write;
    logic [2:0] out_mem_size;
    logic       out_jump;
    logic       out_illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_alu_ctrl, out_take_branch,
               out_op_a_sel, out_op_b_sel, out_imm, out_rs1, out_rs2, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_mem_size,
               out_jump, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_ctrl, out_take_branch,
               out_op_a_sel, out_op_b_sel, out_imm, out_rs1, out_rs2, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_mem_size,
               out_jump, out_illegal
    );

endinterface

// File: rtl/instr_decoder.sv
// Combinational RV64I decoder: (pc, instr) -> decode_bundle_t.
// Ports: pc (64, in), instr (32, in), bundle (decode_bundle_t, out).
module instr_decoder import decode_stage_pkg::*; (
    input  u64             pc,
    input  u32             instr,
    output decode_bundle_t bundle
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    u64         imm_i, imm_s, imm_b, imm_u, imm_j;
    logic       writes_rd;
    logic       ill;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{52{instr[31]}}, instr[31:20]};
    assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        bundle    = BUNDLE_RESET;
        bundle.pc = pc;
        writes_rd = 1'b0;
        ill       = 1'b0;
        case (opcode)
            OPC_OP: begin
                bundle.alu_ctrl = alu_from_f3(f3, instr[30], 1'b1);
                bundle.rs1 = instr[19:15];
                bundle.rs2 = instr[24:20];
                bundle.rd  = instr[11:7];
                writes_rd  = 1'b1;
                ill = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                bundle.alu_ctrl = alu_from_f3(f3, instr[30], 1'b0);
                bundle.op_b_sel = B_IMM;
                bundle.imm = imm_i;
                bundle.rs1 = instr[19:15];
                bundle.rd  = instr[11:7];
                writes_rd  = 1'b1;
                // RV64 shifts take a 6-bit shamt, so only instr[31:26] is funct6
                if (f3 == 3'b001)
                    ill = (instr[31:26] != 6'b000000);
                else if (f3 == 3'b101)
                    ill = (instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000);
            end
            OPC_BRANCH: begin
                bundle.alu_ctrl = SUB;
                bundle.imm = imm_b;
                bundle.rs1 = instr[19:15];
                bundle.rs2 = instr[24:20];
                case (f3)
                    3'b000:  bundle.take_branch = BEQ;
                    3'b001:  bundle.take_branch = BNE;
                    3'b100:  bundle.take_branch = BLT;
                    3'b101:  bundle.take_branch = BGE;
                    3'b110:  bundle.take_branch = BLTU;
                    3'b111:  bundle.take_branch = BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                bundle.op_b_sel  = B_IMM;
                bundle.imm       = imm_i;
                bundle.rs1       = instr[19:15];
                bundle.rd        = instr[11:7];
                bundle.mem_read  = 1'b1;
                bundle.mem_size  = f3;
                writes_rd        = 1'b1;
                ill              = (f3 == 3'b111);
            end
            OPC_STORE: begin
                bundle.op_b_sel  = B_IMM;
                bundle.imm       = imm_s;
                bundle.rs1       = instr[19:15];
                bundle.rs2       = instr[24:20];
                bundle.mem_write = 1'b1;
                bundle.mem_size  = f3;
                ill              = f3[2];
            end
            OPC_LUI: begin
                bundle.op_a_sel = A_ZERO;
                bundle.op_b_sel = B_IMM;
                bundle.imm      = imm_u;
                bundle.rd       = instr[11:7];
                writes_rd       = 1'b1;
            end
            OPC_AUIPC: begin
                bundle.op_a_sel = A_PC;
                bundle.op_b_sel = B_IMM;
                bundle.imm      = imm_u;
                bundle.rd       = instr[11:7];
                writes_rd       = 1'b1;
            end
            // Jumps compute the link value pc+4 in the ALU; imm carries the target offset.
            OPC_JAL: begin
                bundle.op_a_sel = A_PC;
                bundle.op_b_sel = B_FOUR;
                bundle.imm      = imm_j;
                bundle.rd       = instr[11:7];
                bundle.jump     = 1'b1;
                writes_rd       = 1'b1;
            end
            OPC_JALR: begin
                bundle.op_a_sel = A_PC;
                bundle.op_b_sel = B_FOUR;
                bundle.imm      = imm_i;
                bundle.rs1      = instr[19:15];
                bundle.rd       = instr[11:7];
                bundle.jump     = 1'b1;
                writes_rd       = 1'b1;
                ill             = (f3 != 3'b000);
            end
            default: ill = 1'b1;
        endcase

        bundle.reg_write = writes_rd && !ill && (bundle.rd != 5'd0);
        // Illegal entries still flow downstream, but must not cause side effects.
        if (ill) begin
            bundle.mem_read    = 1'b0;
            bundle.mem_write   = 1'b0;
            bundle.mem_size    = 3'b000;
            bundle.jump        = 1'b0;
            bundle.take_branch = NOBR;
        end
        bundle.illegal = ill;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input, one-entry output register
// holding the decoded bundle, with flush and backpressure.
// Ports: clk, reset (sync, active-high), flush, bus (decode_stage_if.slave).
module decode_stage import decode_stage_pkg::*; (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    decode_bundle_t dec;
    decode_bundle_t q;
    logic           valid_q;
    logic           xfer;

    instr_decoder u_dec (
        .pc     (bus.in_pc),
        .instr  (bus.in_instr),
        .bundle (dec)
    );

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            q       <= BUNDLE_RESET;
        end else begin
            // An instruction arriving with flush is dropped; keep the old data.
            if (xfer && !flush)
                q <= dec;
            if (flush)
                valid_q <= 1'b0;
            else if (xfer)
                valid_q <= 1'b1;
            else if (bus.out_ready)
                valid_q <= 1'b0;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_pc          = q.pc;
    assign bus.out_alu_ctrl    = q.alu_ctrl;
    assign bus.out_take_branch = q.take_branch;
    assign bus.out_op_a_sel    = q.op_a_sel;
    assign bus.out_op_b_sel    = q.op_b_sel;
    assign bus.out_imm         = q.imm;
    assign bus.out_rs1         = q.rs1;
    assign bus.out_rs2         = q.rs2;
    assign bus.out_rd          = q.rd;
    assign bus.out_reg_write   = q.reg_write;
    assign bus.out_mem_read    = q.mem_read;
    assign bus.out_mem_write   = q.mem_write;
    assign bus.out_mem_size    = q.mem_size;
    assign bus.out_jump        = q.jump;
    assign bus.out_illegal     = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table streamed through a
// scoreboard, plus hand-written backpressure, flush and reset sequences.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct {
        u32         instr;
        logic       full;   // 0: illegal entry, only flags are defined
        ALU_CTR     alu;
        BRA         br;
        OPA_SEL     a;
        OPB_SEL     b;
        u64         imm;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr, mw;
        logic [2:0] msz;
        logic       jump, ill;
    } vec_t;

    typedef struct {
        decode_bundle_t b;
        logic           full;
    } exp_t;

    localparam int NV = 17;

    logic clk;
    logic reset;
    logic flush;
    decode_stage_if dif ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs [NV];
    exp_t sb_q [$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    function automatic decode_bundle_t zero_bundle();
        decode_bundle_t b;
        b.pc = '0; b.alu_ctrl = ADD; b.take_branch = NOBR; b.op_a_sel = A_RS1;
        b.op_b_sel = B_RS2; b.imm = '0; b.rs1 = '0; b.rs2 = '0; b.rd = '0;
        b.reg_write = 1'b0; b.mem_read = 1'b0; b.mem_write = 1'b0;
        b.mem_size = '0; b.jump = 1'b0; b.illegal = 1'b0;
        return b;
    endfunction

    function automatic decode_bundle_t to_bundle(input vec_t v, input u64 pc);
        decode_bundle_t b;
        b.pc = pc; b.alu_ctrl = v.alu; b.take_branch = v.br; b.op_a_sel = v.a;
        b.op_b_sel = v.b; b.imm = v.imm; b.rs1 = v.rs1; b.rs2 = v.rs2; b.rd = v.rd;
        b.reg_write = v.rw; b.mem_read = v.mr; b.mem_write = v.mw;
        b.mem_size = v.msz; b.jump = v.jump; b.illegal = v.ill;
        return b;
    endfunction

    function automatic decode_bundle_t get_out();
        decode_bundle_t b;
        b.pc = dif.out_pc; b.alu_ctrl = dif.out_alu_ctrl;
        b.take_branch = dif.out_take_branch; b.op_a_sel = dif.out_op_a_sel;
        b.op_b_sel = dif.out_op_b_sel; b.imm = dif.out_imm; b.rs1 = dif.out_rs1;
        b.rs2 = dif.out_rs2; b.rd = dif.out_rd; b.reg_write = dif.out_reg_write;
        b.mem_read = dif.out_mem_read; b.mem_write = dif.out_mem_write;
        b.mem_size = dif.out_mem_size; b.jump = dif.out_jump;
        b.illegal = dif.out_illegal;
        return b;
    endfunction

    function automatic logic [191:0] flag_view(input decode_bundle_t b);
        return 192'({b.pc, b.illegal, b.take_branch, b.reg_write, b.mem_read,
                     b.mem_write, b.jump});
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_sample();
        exp_t e;
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (dif.out_valid && dif.out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h, expected no output", dif.out_pc);
                end else begin
                    e = sb_q.pop_front();
                    if (e.full)
                        chk("bundle", 192'(get_out()), 192'(e.b));
                    else
                        chk("illegal_flags", flag_view(get_out()), flag_view(e.b));
                end
            end
            if (dif.in_valid && dif.in_ready)
                sb_q.push_back(cur_exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input u64 pc);
        dif.in_valid = 1'b1;
        dif.in_pc    = pc;
        dif.in_instr = vecs[idx].instr;
        cur_exp.b    = to_bundle(vecs[idx], pc);
        cur_exp.full = vecs[idx].full;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 5 && sb_q.size() != 0; k++)
            step();
        chk(name, 192'(sb_q.size()), 192'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        decode_bundle_t snap;
        u64 all1 = 64'hFFFF_FFFF_FFFF_FFFF;

        //          instr         full  alu   br    a       b       imm                     rs1    rs2    rd     rw    mr    mw    msz   jmp   ill
        vecs[0]  = '{32'hFFF00093, 1'b1, ADD,  NOBR, A_RS1,  B_IMM,  all1,                   5'd0,  5'd0,  5'd1,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{32'h402081B3, 1'b1, SUB,  NOBR, A_RS1,  B_RS2,  64'h0,                  5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE209EE3, 1'b1, SUB,  BNE,  A_RS1,  B_RS2,  64'hFFFF_FFFF_FFFF_FFFC, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{32'hFE20AEE3, 1'b0, ADD,  NOBR, A_RS1,  B_RS2,  64'h0,                  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[4]  = '{32'h43F35293, 1'b1, SRA,  NOBR, A_RS1,  B_IMM,  64'h43F,                5'd6,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{32'h03F35293, 1'b1, SRL,  NOBR, A_RS1,  B_IMM,  64'h03F,                5'd6,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{32'h800003B7, 1'b1, ADD,  NOBR, A_ZERO, B_IMM,  64'hFFFF_FFFF_8000_0000, 5'd0,  5'd0,  5'd7,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{32'h00001117, 1'b1, ADD,  NOBR, A_PC,   B_IMM,  64'h1000,               5'd0,  5'd0,  5'd2,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[8]  = '{32'h008000EF, 1'b1, ADD,  NOBR, A_PC,   B_FOUR, 64'h8,                  5'd0,  5'd0,  5'd1,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{32'h00008067, 1'b1, ADD,  NOBR, A_PC,   B_FOUR, 64'h0,                  5'd1,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[10] = '{32'h01013503, 1'b1, ADD,  NOBR, A_RS1,  B_IMM,  64'h10,                 5'd2,  5'd0,  5'd10, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{32'hFE512C23, 1'b1, ADD,  NOBR, A_RS1,  B_IMM,  64'hFFFF_FFFF_FFFF_FFF8, 5'd2,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        vecs[12] = '{32'h0000007F, 1'b0, ADD,  NOBR, A_RS1,  B_RS2,  64'h0,                  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[13] = '{32'h0062E233, 1'b1, OR,   NOBR, A_RS1,  B_RS2,  64'h0,                  5'd5,  5'd6,  5'd4,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[14] = '{32'h00512093, 1'b1, SLT,  NOBR, A_RS1,  B_IMM,  64'h5,                  5'd2,  5'd0,  5'd1,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[15] = '{32'h00208033, 1'b1, ADD,  NOBR, A_RS1,  B_RS2,  64'h0,                  5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[16] = '{32'h02208033, 1'b0, ADD,  NOBR, A_RS1,  B_RS2,  64'h0,                  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};

        reset = 1'b1;
        flush = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_pc     = '0;
        dif.in_instr  = '0;
        dif.out_ready = 1'b0;
        cur_exp.b     = zero_bundle();
        cur_exp.full  = 1'b1;
        repeat (3) step();

        // Reset state, observed in the cycle after reset deasserts.
        reset = 1'b0;
        #1;
        chk("reset_out_valid", 192'(dif.out_valid), 192'(1'b0));
        chk("reset_bundle", 192'(get_out()), 192'(zero_bundle()));
        chk("reset_in_ready", 192'(dif.in_ready), 192'(1'b1));

        // Table: full-throughput stream through the scoreboard.
        dif.out_ready = 1'b1;
        n_out = 0;
        for (int i = 0; i < NV; i++) begin
            drive(i, 64'h8000_0000 + 64'(4 * i));
            step();
            chk("latency_valid", 192'(dif.out_valid), 192'(1'b1));
            chk("latency_pc", 192'(dif.out_pc), 192'(64'h8000_0000 + 64'(4 * i)));
        end
        dif.in_valid = 1'b0;
        drain("table_drain");
        chk("table_outputs", 192'(n_out), 192'(NV));

        // Backpressure: hold A for 3 cycles with B waiting, then release.
        dif.out_ready = 1'b0;
        drive(0, 64'h1000);
        step();
        snap = get_out();
        chk("bp_captured", 192'(snap), 192'(to_bundle(vecs[0], 64'h1000)));
        drive(1, 64'h1004);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_in_ready", 192'(dif.in_ready), 192'(1'b0));
            chk("bp_valid", 192'(dif.out_valid), 192'(1'b1));
            chk("bp_stable", 192'(get_out()), 192'(snap));
        end
        dif.out_ready = 1'b1;
        step();
        dif.in_valid = 1'b0;
        chk("bp_next_valid", 192'(dif.out_valid), 192'(1'b1));
        chk("bp_next_pc", 192'(dif.out_pc), 192'(64'h1004));
        step();
        chk("bp_no_dup", 192'(dif.out_valid), 192'(1'b0));
        drain("bp_drain");

        // Flush with a held entry and a coinciding transfer.
        dif.out_ready = 1'b0;
        drive(2, 64'h2000);
        step();
        drive(4, 64'h2004);
        dif.out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 192'(dif.in_ready), 192'(1'b1));
        step();
        flush = 1'b0;
        dif.in_valid = 1'b0;
        chk("flush_valid", 192'(dif.out_valid), 192'(1'b0));
        step();
        chk("flush_dropped", 192'(dif.out_valid), 192'(1'b0));

        // Reset (with flush) in the middle of a stream.
        drive(0, 64'h3000);
        step();
        drive(1, 64'h3004);
        step();
        reset = 1'b1;
        flush = 1'b1;
        drive(6, 64'h3008);
        step();
        chk("midrst_valid", 192'(dif.out_valid), 192'(1'b0));
        chk("midrst_bundle", 192'(get_out()), 192'(zero_bundle()));
        reset = 1'b0;
        flush = 1'b0;
        dif.in_valid = 1'b0;
        #1;
        chk("midrst_in_ready", 192'(dif.in_ready), 192'(1'b1));
        step();
        chk("midrst_idle", 192'(dif.out_valid), 192'(1'b0));

        // Recovery after reset.
        drive(13, 64'h4000);
        step();
        dif.in_valid = 1'b0;
        drain("recover_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
